mips32_pc_unit: RTL and testbench

- Parametrised program-counter and next-PC unit for the MIPS32 SoC.
- Owns the PC register, the next-PC select (sequential/branch/jump/jump-register) and the virtual-to-physical instruction address decode.
- Adds a stall input, an explicit RUN/HALT state machine with a latched fault cause, and a retired-instruction counter.
- Sits between the control unit/ALU and the instruction memory.

---
 rtl/mips32_pkg.sv | 10 +
 rtl/mips32_pc_unit_if.sv | 34 +++
 rtl/mips32_pc_decoder.sv | 18 +
 rtl/mips32_pc_unit.sv | 75 +++++++
 tb/tb_mips32_pc_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared types and constants for the PC unit and the memory decoders.
package mips32_pkg;
    typedef enum logic {RUN, HALT} state_t;
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_PC   = 2'd1;
    localparam logic [1:0] CAUSE_OPC  = 2'd2;
    localparam logic [1:0] CAUSE_ADDR = 2'd3;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE    = 32'h0040_0000;
endpackage

// File: rtl/mips32_pc_unit_if.sv
// mips32_pc_unit_if: control/ALU side of the PC unit and its instruction-fetch outputs.
interface mips32_pc_unit_if #(
    parameter int PHYS_AW = 10,
    parameter int CNT_W   = 32
);
    logic               stall;
    logic               isJmp;
    logic               isJr;
    logic               isBeq;
    logic               isBne;
    logic               isZero;
    logic [25:0]        instIndex;
    logic [31:0]        imm32;
    logic [31:0]        jrAddr;
    logic               invalidOpcode;
    logic               invalidAddr;
    logic [31:0]        pc;
    logic [31:0]        pcPlus4;
    logic [PHYS_AW-1:0] physicalPC;
    logic               invalidPC;
    logic               halted;
    logic [1:0]         haltCause;
    logic [CNT_W-1:0]   retired;
    modport master (
        output stall, isJmp, isJr, isBeq, isBne, isZero, instIndex, imm32, jrAddr,
               invalidOpcode, invalidAddr,
        input  pc, pcPlus4, physicalPC, invalidPC, halted, haltCause, retired
    );
    modport slave (
        input  stall, isJmp, isJr, isBeq, isBne, isZero, instIndex, imm32, jrAddr,
               invalidOpcode, invalidAddr,
        output pc, pcPlus4, physicalPC, invalidPC, halted, haltCause, retired
    );
endinterface

// File: rtl/mips32_pc_decoder.sv
// mips32_pc_decoder: virtual PC to instruction-memory word address plus range/alignment check.
module mips32_pc_decoder import mips32_pkg::*; #(
    parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
    parameter int          TEXT_WORDS = 1024,
    parameter int          PHYS_AW    = 10
) (
    input  logic [31:0]        i_pc,
    output logic [PHYS_AW-1:0] o_physical_pc,
    output logic               o_invalid_pc
);
    // 33-bit bounds so TEXT_BASE + size cannot wrap past 2^32
    localparam logic [32:0] LO = {1'b0, TEXT_BASE};
    localparam logic [32:0] HI = LO + (33'(TEXT_WORDS) << 2);
    logic [32:0] w_pc33;
    assign w_pc33        = {1'b0, i_pc};
    assign o_invalid_pc  = (|i_pc[1:0]) | (w_pc33 < LO) | (w_pc33 >= HI);
    assign o_physical_pc = PHYS_AW'((i_pc - TEXT_BASE) >> 2);
endmodule

// File: rtl/mips32_pc_unit.sv
// mips32_pc_unit: PC register, next-PC select, RUN/HALT fault FSM and retired counter.
module mips32_pc_unit import mips32_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TEXT_BASE    = DEFAULT_TEXT_BASE,
    parameter int          TEXT_WORDS   = 1024,
    parameter int          PHYS_AW      = 10,
    parameter int          CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    mips32_pc_unit_if.slave bus
);
    state_t           r_state, w_state_n;
    logic [31:0]      r_pc, w_pc_n;
    logic [1:0]       r_cause, w_cause_n;
    logic [CNT_W-1:0] r_retired, w_retired_n;
    logic [31:0]      w_pc_plus4, w_next_pc;
    logic             w_branch, w_invalid_pc, w_fault;
    logic [PHYS_AW-1:0] w_physical_pc;

    mips32_pc_decoder #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_WORDS(TEXT_WORDS),
        .PHYS_AW   (PHYS_AW)
    ) u_dec (
        .i_pc         (r_pc),
        .o_physical_pc(w_physical_pc),
        .o_invalid_pc (w_invalid_pc)
    );

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_branch   = (bus.isBeq & bus.isZero) | (bus.isBne & ~bus.isZero);
    assign w_next_pc  = bus.isJr  ? bus.jrAddr :
                        bus.isJmp ? {w_pc_plus4[31:28], bus.instIndex, 2'b00} :
                        w_branch  ? w_pc_plus4 + (bus.imm32 << 2) : w_pc_plus4;
    assign w_fault    = w_invalid_pc | bus.invalidOpcode | bus.invalidAddr;

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_cause_n   = r_cause;
        w_retired_n = r_retired;
        if (r_state == RUN) begin
            if (w_fault) begin
                w_state_n = HALT;
                w_cause_n = w_invalid_pc ? CAUSE_PC : bus.invalidOpcode ? CAUSE_OPC : CAUSE_ADDR;
            end else if (!bus.stall) begin
                w_pc_n      = w_next_pc;
                w_retired_n = &r_retired ? r_retired : r_retired + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_pc      <= RESET_VECTOR;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_cause   <= w_cause_n;
            r_retired <= w_retired_n;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.pcPlus4    = w_pc_plus4;
    assign bus.physicalPC = w_physical_pc;
    assign bus.invalidPC  = w_invalid_pc;
    assign bus.halted     = (r_state == HALT);
    assign bus.haltCause  = r_cause;
    assign bus.retired    = r_retired;
endmodule

// File: tb/tb_mips32_pc_unit.sv
// tb_mips32_pc_unit: directed scenarios plus a randomized run against a behavioural PC model.
module tb_mips32_pc_unit;
    import mips32_pkg::*;
    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] TB = 32'h0040_0000;
    localparam int WORDS = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;
    int total = 0;
    int bad = 0;

    logic [31:0] m_pc;
    logic        m_halt;
    logic [1:0]  m_cause;
    logic [31:0] m_ret;

    mips32_pc_unit_if #(.PHYS_AW(10), .CNT_W(32)) bus();
    mips32_pc_unit_if #(.PHYS_AW(10), .CNT_W(2))  bus2();

    mips32_pc_unit #(.RESET_VECTOR(RV), .TEXT_BASE(TB), .TEXT_WORDS(WORDS), .PHYS_AW(10), .CNT_W(32))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mips32_pc_unit #(.RESET_VECTOR(RV), .TEXT_BASE(TB), .TEXT_WORDS(WORDS), .PHYS_AW(10), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

    always #5 clk = ~clk;

    function automatic logic m_invalid(input logic [31:0] p);
        longint v;
        v = longint'(p);
        return (v % 4 != 0) || (v < longint'(TB)) || (v >= longint'(TB) + 4 * WORDS);
    endfunction

    // Reference: the architectural rules evaluated on plain integers.
    task automatic model_step();
        logic inv;
        logic [31:0] nxt;
        if (rst) begin
            m_pc = RV; m_halt = 1'b0; m_cause = 2'd0; m_ret = 0;
        end else if (!m_halt) begin
            inv = m_invalid(m_pc);
            if (inv || bus.invalidOpcode || bus.invalidAddr) begin
                m_halt = 1'b1;
                m_cause = inv ? 2'd1 : bus.invalidOpcode ? 2'd2 : 2'd3;
            end else if (!bus.stall) begin
                if (bus.isJr) nxt = bus.jrAddr;
                else if (bus.isJmp) nxt = ((m_pc + 4) & 32'hF000_0000) + {bus.instIndex, 2'b00};
                else if ((bus.isBeq && bus.isZero) || (bus.isBne && !bus.isZero)) nxt = m_pc + 4 + bus.imm32 * 4;
                else nxt = m_pc + 4;
                m_pc = nxt;
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.isJmp = 0; bus.isJr = 0; bus.isBeq = 0; bus.isBne = 0; bus.isZero = 0;
        bus.instIndex = '0; bus.imm32 = '0; bus.jrAddr = '0; bus.invalidOpcode = 0; bus.invalidAddr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.pc !== RV) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RV); end
        total++; if (bus.halted !== 1'b0 || bus.haltCause !== CAUSE_NONE || bus.retired !== 32'd0) begin
            bad++; $display("FAIL reset_state got halted=%b cause=%0d retired=%0d exp 0/0/0", bus.halted, bus.haltCause, bus.retired); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (bus.pc !== RV + 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.pc, RV + 32'(4 * i)); end
        end
        total++; if (bus.retired !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d exp=3", bus.retired); end
        total++; if (bus.physicalPC !== 10'd3) begin bad++; $display("FAIL seq_phys got=%0d exp=3", bus.physicalPC); end
        total++; if (bus.pcPlus4 !== 32'h0040_0010) begin bad++; $display("FAIL seq_pcplus4 got=%h exp=00400010", bus.pcPlus4); end
    endtask

    task automatic test_branch();
        for (int z = 0; z < 2; z++) begin
            do_reset();
            repeat (4) tick();
            bus.isBne = 1; bus.isZero = 1'(z); bus.imm32 = 32'hFFFF_FFFE;
            tick();
            idle();
            total++; if (bus.pc !== (z == 0 ? 32'h0040_000C : 32'h0040_0014)) begin
                bad++; $display("FAIL bne_zero%0d got=%h exp=%h", z, bus.pc, (z == 0 ? 32'h0040_000C : 32'h0040_0014)); end
        end
        do_reset();
        bus.isBeq = 1; bus.isZero = 1; bus.imm32 = 32'd3;
        tick();
        idle();
        total++; if (bus.pc !== 32'h0040_0010) begin bad++; $display("FAIL beq_taken got=%h exp=00400010", bus.pc); end
    endtask

    task automatic test_jump();
        do_reset();
        bus.isJmp = 1; bus.instIndex = 26'h010_0020;
        tick();
        total++; if (bus.pc !== 32'h0040_0080) begin bad++; $display("FAIL jmp got=%h exp=00400080", bus.pc); end
        do_reset();
        bus.isJmp = 1; bus.isJr = 1; bus.instIndex = 26'h010_0020; bus.jrAddr = 32'h0040_0100;
        tick();
        idle();
        total++; if (bus.pc !== 32'h0040_0100) begin bad++; $display("FAIL jr_over_jmp got=%h exp=00400100", bus.pc); end
        total++; if (bus.physicalPC !== 10'd64) begin bad++; $display("FAIL jr_phys got=%0d exp=64", bus.physicalPC); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) tick();
        bus.stall = 1; bus.isJmp = 1; bus.instIndex = 26'h3;
        repeat (2) begin
            tick();
            total++; if (bus.pc !== 32'h0040_0008 || bus.retired !== 32'd2) begin
                bad++; $display("FAIL stall_hold got pc=%h retired=%0d exp pc=00400008 retired=2", bus.pc, bus.retired); end
        end
        idle();
        tick();
        total++; if (bus.pc !== 32'h0040_000C) begin bad++; $display("FAIL stall_release got=%h exp=0040000c", bus.pc); end
    endtask

    task automatic test_fault();
        do_reset();
        bus.isJr = 1; bus.jrAddr = 32'h0040_0002;
        tick();
        idle();
        total++; if (bus.pc !== 32'h0040_0002 || bus.invalidPC !== 1'b1 || bus.halted !== 1'b0) begin
            bad++; $display("FAIL misaligned_load got pc=%h inv=%b halted=%b exp 00400002/1/0", bus.pc, bus.invalidPC, bus.halted); end
        tick();
        total++; if (bus.halted !== 1'b1 || bus.haltCause !== CAUSE_PC || bus.pc !== 32'h0040_0002) begin
            bad++; $display("FAIL pc_fault got halted=%b cause=%0d pc=%h exp 1/1/00400002", bus.halted, bus.haltCause, bus.pc); end
        bus.isJr = 1; bus.jrAddr = 32'h0040_0040; bus.invalidOpcode = 1;
        repeat (2) tick();
        total++; if (bus.pc !== 32'h0040_0002 || bus.haltCause !== CAUSE_PC || bus.retired !== 32'd1 || bus.halted !== 1'b1) begin
            bad++; $display("FAIL halt_frozen got pc=%h cause=%0d retired=%0d exp 00400002/1/1", bus.pc, bus.haltCause, bus.retired); end
        do_reset();
        total++; if (bus.pc !== RV || bus.halted !== 1'b0 || bus.haltCause !== CAUSE_NONE || bus.retired !== 32'd0) begin
            bad++; $display("FAIL halt_reset got pc=%h halted=%b cause=%0d retired=%0d", bus.pc, bus.halted, bus.haltCause, bus.retired); end
        bus.invalidOpcode = 1; bus.invalidAddr = 1; bus.stall = 1;
        tick();
        idle();
        total++; if (bus.halted !== 1'b1 || bus.haltCause !== CAUSE_OPC || bus.pc !== RV) begin
            bad++; $display("FAIL opc_fault got halted=%b cause=%0d pc=%h exp 1/2/%h", bus.halted, bus.haltCause, bus.pc, RV); end
        do_reset();
        tick();
        bus.invalidAddr = 1;
        tick();
        idle();
        total++; if (bus.halted !== 1'b1 || bus.haltCause !== CAUSE_ADDR || bus.pc !== 32'h0040_0004) begin
            bad++; $display("FAIL addr_fault got halted=%b cause=%0d pc=%h exp 1/3/00400004", bus.halted, bus.haltCause, bus.pc); end
        do_reset();
        bus.isJr = 1; bus.jrAddr = TB + 32'(4 * WORDS);
        tick();
        idle();
        total++; if (bus.invalidPC !== 1'b1) begin bad++; $display("FAIL upper_bound got=%b exp=1", bus.invalidPC); end
        do_reset();
        bus.isJr = 1; bus.jrAddr = TB + 32'(4 * WORDS - 4);
        tick();
        idle();
        total++; if (bus.invalidPC !== 1'b0 || bus.physicalPC !== 10'd1023) begin
            bad++; $display("FAIL last_word got inv=%b phys=%0d exp 0/1023", bus.invalidPC, bus.physicalPC); end
        do_reset();
        bus.isJr = 1; bus.jrAddr = TB - 4;
        tick();
        idle();
        total++; if (bus.invalidPC !== 1'b1) begin bad++; $display("FAIL below_base got=%b exp=1", bus.invalidPC); end
    endtask

    task automatic test_saturation();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        total++; if (bus2.retired !== 2'd0) begin bad++; $display("FAIL sat_reset got=%0d exp=0", bus2.retired); end
        repeat (5) tick();
        total++; if (bus2.retired !== 2'd3 || bus2.pc !== RV + 32'd20) begin
            bad++; $display("FAIL sat_retired got retired=%0d pc=%h exp 3/%h", bus2.retired, bus2.pc, RV + 32'd20); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.stall  = ($urandom_range(0, 5) == 0);
            bus.isJr   = ($urandom_range(0, 9) == 0);
            bus.isJmp  = ($urandom_range(0, 9) == 0);
            bus.isBeq  = ($urandom_range(0, 4) == 0);
            bus.isBne  = ($urandom_range(0, 4) == 0);
            bus.isZero = 1'($urandom);
            bus.instIndex = 26'(TB >> 2) + 26'($urandom_range(0, WORDS + 8));
            bus.imm32  = 32'($urandom_range(0, 64)) - 32'd32;
            bus.jrAddr = TB + 32'($urandom_range(0, WORDS + 4) * 4) + 32'($urandom_range(0, 15) == 0 ? $urandom_range(1, 3) : 0);
            bus.invalidOpcode = ($urandom_range(0, 60) == 0);
            bus.invalidAddr   = ($urandom_range(0, 60) == 0);
            rst = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 200) == 0);
            tick();
            total++; if (bus.pc !== m_pc || bus.pcPlus4 !== m_pc + 32'd4) begin
                bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, bus.pc, m_pc); end
            total++; if (bus.halted !== m_halt || bus.haltCause !== m_cause || bus.retired !== m_ret) begin
                bad++; $display("FAIL rnd_state n=%0d got h=%b c=%0d r=%0d exp h=%b c=%0d r=%0d", n, bus.halted, bus.haltCause, bus.retired, m_halt, m_cause, m_ret); end
            total++; if (bus.invalidPC !== m_invalid(m_pc)) begin
                bad++; $display("FAIL rnd_invalid n=%0d got=%b exp=%b", n, bus.invalidPC, m_invalid(m_pc)); end
            if (!m_invalid(m_pc)) begin
                total++; if (bus.physicalPC !== 10'((m_pc - TB) / 4)) begin
                    bad++; $display("FAIL rnd_phys n=%0d got=%0d exp=%0d", n, bus.physicalPC, 10'((m_pc - TB) / 4)); end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        bus2.stall = 0; bus2.isJmp = 0; bus2.isJr = 0; bus2.isBeq = 0; bus2.isBne = 0; bus2.isZero = 0;
        bus2.instIndex = '0; bus2.imm32 = '0; bus2.jrAddr = '0; bus2.invalidOpcode = 0; bus2.invalidAddr = 0;
        m_pc = RV; m_halt = 1'b0; m_cause = 2'd0; m_ret = 0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_fault();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
